aha_sif_rd_buffer: RTL and testbench

Read-return stage between the AXI-to-simple-interface read front end and the CGRA data read port.
- Issues single-beat read requests to the CGRA.
- Tracks each request's ID/LAST tag through the CGRA's fixed read latency.
- Captures the returned 64-bit data into a small FIFO and presents it as a valid/ready stream toward the AXI R channel.
- Applies credit-based flow control, so CGRA read data, which cannot be stalled, is never dropped.

---
 rtl/aha_sif_pkg.sv | 24 ++
 rtl/aha_sif_sync_fifo.sv | 75 +++++++
 rtl/aha_sif_rd_buffer.sv | 145 ++++++++++++++
 tb/tb_aha_sif_rd_buffer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aha_sif_pkg.sv
// -----------------------------------------------------------------------------
// aha_sif_pkg
// Shared types and default widths for the simple-interface (SIF) read path.
//   SIF_DATA_W / SIF_ADDR_W / SIF_ID_W : default data, address and AXI ID widths
//   sif_rd_tag_t                       : per-beat tag {last, id}
//   sif_rd_beat_t                      : returned beat {data, tag}
// -----------------------------------------------------------------------------
package aha_sif_pkg;

  localparam int unsigned SIF_DATA_W = 64;
  localparam int unsigned SIF_ADDR_W = 32;
  localparam int unsigned SIF_ID_W   = 4;

  typedef struct packed {
    logic                last;
    logic [SIF_ID_W-1:0] id;
  } sif_rd_tag_t;

  typedef struct packed {
    logic [SIF_DATA_W-1:0] data;
    sif_rd_tag_t           tag;
  } sif_rd_beat_t;

endpackage

// File: rtl/aha_sif_sync_fifo.sv
// -----------------------------------------------------------------------------
// aha_sif_sync_fifo
// Single-clock FIFO with first-word-fall-through head output.
// Simultaneous push and pop on a full FIFO is legal (head advances, tail
// is written). Storage is cleared on reset so the head reads zero.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_push, i_push_data   : write request and data
//   i_pop                 : advance head (ignored when empty)
//   o_full, o_empty       : status
//   o_head                : current head entry
// -----------------------------------------------------------------------------
module aha_sif_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_push;
  logic w_pop;

  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && o_full && !i_pop))
    else $error("aha_sif_sync_fifo: push while full");
`endif

endmodule

// File: rtl/aha_sif_rd_buffer.sv
// -----------------------------------------------------------------------------
// aha_sif_rd_buffer
// Read-return stage: issues single-beat reads to the CGRA, carries each
// request's {id,last} tag through the fixed RD_WS read latency, captures the
// returned data into a DEPTH-entry FIFO and presents it as a valid/ready
// stream. A credit counter (issued but not yet popped) bounds outstanding
// reads to DEPTH, so unstallable CGRA data always finds FIFO space.
// Optional feature macro: AHA_SIF_RD_BYPASS_EN -- when the FIFO is empty a
// returning beat is presented combinationally and, if accepted, skips the FIFO.
// Ports:
//   CLK, RESET                         : clock, synchronous active-high reset
//   REQ_VALID/READY/ADDR/ID/LAST       : read request (one beat)
//   SIF_RD_EN, SIF_RD_ADDR             : CGRA read strobe and address
//   SIF_RD_DATA                        : CGRA data, valid RD_WS cycles after EN
//   RSP_VALID/READY/DATA/ID/LAST       : response stream toward AXI R
//   OCCUPANCY                          : in-flight + buffered beats (debug)
// -----------------------------------------------------------------------------
module aha_sif_rd_buffer
  import aha_sif_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SIF_ADDR_W,
  parameter int unsigned DATA_WIDTH = SIF_DATA_W,
  parameter int unsigned ID_WIDTH   = SIF_ID_W,
  parameter int unsigned RD_WS      = 1,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  input  logic [ADDR_WIDTH-1:0]     REQ_ADDR,
  input  logic [ID_WIDTH-1:0]       REQ_ID,
  input  logic                      REQ_LAST,
  output logic                      SIF_RD_EN,
  output logic [ADDR_WIDTH-1:0]     SIF_RD_ADDR,
  input  logic [DATA_WIDTH-1:0]     SIF_RD_DATA,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [DATA_WIDTH-1:0]     RSP_DATA,
  output logic [ID_WIDTH-1:0]       RSP_ID,
  output logic                      RSP_LAST,
  output logic [$clog2(DEPTH):0]    OCCUPANCY
);

  localparam int unsigned OW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = DATA_WIDTH + ID_WIDTH + 1;
  localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);

  logic [OW-1:0]       r_occ;
  logic                r_tag_vld  [RD_WS];
  logic [ID_WIDTH-1:0] r_tag_id   [RD_WS];
  logic                r_tag_last [RD_WS];

  logic          w_issue;
  logic          w_cap;
  logic          w_push;
  logic          w_fifo_pop;
  logic          w_rsp_fire;
  logic          w_full;
  logic          w_empty;
  logic [EW-1:0] w_cap_beat;
  logic [EW-1:0] w_head;

  // Issue path: ready is decoded from the credit register only.
  assign REQ_READY   = (r_occ < OCC_MAX);
  assign w_issue     = REQ_VALID & REQ_READY & ~RESET;
  assign SIF_RD_EN   = w_issue;
  assign SIF_RD_ADDR = REQ_ADDR;
  assign OCCUPANCY   = r_occ;

  assign w_cap      = r_tag_vld[RD_WS-1];
  assign w_cap_beat = {SIF_RD_DATA, r_tag_id[RD_WS-1], r_tag_last[RD_WS-1]};

`ifdef AHA_SIF_RD_BYPASS_EN
  logic w_byp;
  // Empty FIFO plus an arriving beat: present it directly; only buffer it
  // if the consumer does not take it this cycle.
  assign w_byp     = w_empty & w_cap;
  assign RSP_VALID = ~w_empty | w_cap;
  assign {RSP_DATA, RSP_ID, RSP_LAST} = w_byp ? w_cap_beat : w_head;
  assign w_push    = w_cap & ~(w_byp & RSP_READY);
`else
  assign RSP_VALID = ~w_empty;
  assign {RSP_DATA, RSP_ID, RSP_LAST} = w_head;
  assign w_push    = w_cap;
`endif

  assign w_rsp_fire = RSP_VALID & RSP_READY;
  assign w_fifo_pop = ~w_empty & RSP_READY;

  // Tag pipeline: free-running shift, never stalls (CGRA cannot stall).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < RD_WS; i++) begin
        r_tag_vld[i]  <= 1'b0;
        r_tag_id[i]   <= '0;
        r_tag_last[i] <= 1'b0;
      end
    end else begin
      r_tag_vld[0]  <= w_issue;
      r_tag_id[0]   <= REQ_ID;
      r_tag_last[0] <= REQ_LAST;
      for (int unsigned i = 1; i < RD_WS; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_id[i]   <= r_tag_id[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end
    end
  end

  // Credits: +1 per issue, -1 per beat delivered downstream.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_occ <= '0;
    end else if (w_issue && !w_rsp_fire) begin
      r_occ <= r_occ + 1'b1;
    end else if (!w_issue && w_rsp_fire) begin
      r_occ <= r_occ - 1'b1;
    end
  end

  aha_sif_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_push      (w_push),
    .i_push_data (w_cap_beat),
    .i_pop       (w_fifo_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

`ifndef SYNTHESIS
  a_no_occ_underflow: assert property (@(posedge CLK) disable iff (RESET)
    !(w_rsp_fire && r_occ == '0))
    else $error("aha_sif_rd_buffer: occupancy underflow");
  a_no_push_full: assert property (@(posedge CLK) disable iff (RESET)
    !(w_push && w_full && !w_fifo_pop))
    else $error("aha_sif_rd_buffer: capture into full FIFO");
`endif

endmodule

// File: tb/tb_aha_sif_rd_buffer.sv
module tb_aha_sif_rd_buffer;
  import aha_sif_pkg::*;

  localparam int unsigned RDW   = 2;
  localparam int unsigned DEPTH = 4;
`ifdef AHA_SIF_RD_BYPASS_EN
  localparam int unsigned LAT = RDW;
`else
  localparam int unsigned LAT = RDW + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_id = '0;
  logic        req_last = 1'b0;
  logic        sif_rd_en;
  logic [31:0] sif_rd_addr;
  logic [63:0] sif_rd_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_id;
  logic        rsp_last;
  logic [2:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aha_sif_rd_buffer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .ID_WIDTH   (4),
    .RD_WS      (RDW),
    .DEPTH      (DEPTH)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .REQ_VALID   (req_valid),
    .REQ_READY   (req_ready),
    .REQ_ADDR    (req_addr),
    .REQ_ID      (req_id),
    .REQ_LAST    (req_last),
    .SIF_RD_EN   (sif_rd_en),
    .SIF_RD_ADDR (sif_rd_addr),
    .SIF_RD_DATA (sif_rd_data),
    .RSP_VALID   (rsp_valid),
    .RSP_READY   (rsp_ready),
    .RSP_DATA    (rsp_data),
    .RSP_ID      (rsp_id),
    .RSP_LAST    (rsp_last),
    .OCCUPANCY   (occupancy)
  );

  // CGRA memory model: fixed latency, not affected by the buffer's reset.
  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return {32'hDEAD_BEEF, a ^ 32'h0000_0101};
  endfunction

  function automatic sif_rd_beat_t exp_beat(input logic [31:0] a, input logic [3:0] id,
                                            input logic last);
    sif_rd_beat_t b;
    b.data     = mem_data(a);
    b.tag.id   = id;
    b.tag.last = last;
    return b;
  endfunction

  logic        pv [RDW] = '{default: 1'b0};
  logic [31:0] pa [RDW] = '{default: 32'h0};
  always @(posedge clk) begin
    pv[0] <= sif_rd_en;
    pa[0] <= sif_rd_addr;
    for (int i = 1; i < RDW; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign sif_rd_data = pv[RDW-1] ? mem_data(pa[RDW-1]) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h50;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (sif_rd_en !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", sif_rd_en); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 64'h0) begin failures++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (rsp_id !== 4'h0 || rsp_last !== 1'b0) begin failures++; $display("FAIL rst_rsp_tag got=%h/%b exp=0/0", rsp_id, rsp_last); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_single;
    sif_rd_beat_t e;
    e = exp_beat(32'h100, 4'd3, 1'b1);
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h100; req_id = 4'd3; req_last = 1'b1;
    @(negedge clk);
    checks++; if (sif_rd_en !== 1'b1) begin failures++; $display("FAIL single_en got=%b exp=1", sif_rd_en); end
    checks++; if (sif_rd_addr !== 32'h100) begin failures++; $display("FAIL single_addr got=%h exp=100", sif_rd_addr); end
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== (k == LAT)) begin
        failures++; $display("FAIL single_valid k=%0d got=%b exp=%b", k, rsp_valid, (k == LAT));
      end
      checks++;
      if (occupancy !== ((k <= LAT) ? 3'd1 : 3'd0)) begin
        failures++; $display("FAIL single_occ k=%0d got=%0d", k, occupancy);
      end
      if (k == LAT) begin
        checks++;
        if (rsp_data !== 64'hDEADBEEF_00000001 || rsp_id !== e.tag.id || rsp_last !== e.tag.last) begin
          failures++; $display("FAIL single_beat got=%h/%h/%b exp=%h/%h/%b", rsp_data, rsp_id, rsp_last,
                               e.data, e.tag.id, e.tag.last);
        end
      end
    end
  endtask

  task automatic test_credit;
    int n_acc;
    int n;
    n_acc = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 32'h300 + 32'(8 * n_acc); req_id = 4'(n_acc); req_last = 1'b0;
      @(negedge clk);
      if (sif_rd_en) n_acc++;
    end
    checks++; if (n_acc != 4) begin failures++; $display("FAIL credit_pulses got=%0d exp=4", n_acc); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL credit_ready_full got=%b exp=0", req_ready); end
    checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL credit_occ_full got=%0d exp=4", occupancy); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== mem_data(32'h300)) begin
      failures++; $display("FAIL credit_head got=%b/%h exp=1/%h", rsp_valid, rsp_data, mem_data(32'h300));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0 || sif_rd_en !== 1'b0) begin
      failures++; $display("FAIL credit_pop_cycle got ready=%b en=%b exp 0/0", req_ready, sif_rd_en);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || sif_rd_en !== 1'b1) begin
      failures++; $display("FAIL credit_reissue got ready=%b en=%b exp 1/1", req_ready, sif_rd_en);
    end
    checks++; if (occupancy !== 3'd3 || sif_rd_addr !== 32'h320) begin
      failures++; $display("FAIL credit_reissue_occ got=%0d/%h exp=3/320", occupancy, sif_rd_addr);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (occupancy !== 3'd4 || req_ready !== 1'b0) begin
      failures++; $display("FAIL credit_refull got=%0d/%b exp=4/0", occupancy, req_ready);
    end
    n = 1;
    for (int c = 0; c < 20 && n < 5; c++) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      if (rsp_valid) begin
        checks++;
        if (rsp_data !== mem_data(32'h300 + 32'(8 * n)) || rsp_id !== 4'(n)) begin
          failures++; $display("FAIL credit_drain n=%0d got=%h/%h exp=%h/%h", n, rsp_data, rsp_id,
                               mem_data(32'h300 + 32'(8 * n)), 4'(n));
        end
        n++;
      end
    end
    checks++; if (n != 5) begin failures++; $display("FAIL credit_drain_count got=%0d exp=5", n); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (occupancy !== 3'd0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL credit_empty got=%0d/%b exp=0/0", occupancy, rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    int   n_iss, n_rsp, n_last;
    logic tog;
    n_iss = 0; n_rsp = 0; n_last = 0; tog = 1'b1;
    for (int c = 0; c < 80 && n_rsp < 8; c++) begin
      @(posedge clk); #1;
      req_valid = (n_iss < 8); req_addr = 32'h200 + 32'(8 * n_iss);
      req_id = 4'(n_iss); req_last = (n_iss == 7);
      rsp_ready = tog; tog = ~tog;
      @(negedge clk);
      if (sif_rd_en) n_iss++;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (rsp_data !== mem_data(32'h200 + 32'(8 * n_rsp)) || rsp_id !== 4'(n_rsp) ||
            rsp_last !== (n_rsp == 7)) begin
          failures++; $display("FAIL b2b_beat n=%0d got=%h/%h/%b", n_rsp, rsp_data, rsp_id, rsp_last);
        end
        if (rsp_last) n_last++;
        n_rsp++;
      end
    end
    req_valid = 1'b0;
    checks++; if (n_rsp != 8) begin failures++; $display("FAIL b2b_rsp_count got=%0d exp=8", n_rsp); end
    checks++; if (n_iss != 8) begin failures++; $display("FAIL b2b_iss_count got=%0d exp=8", n_iss); end
    checks++; if (n_last != 1) begin failures++; $display("FAIL b2b_last_count got=%0d exp=1", n_last); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL b2b_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_throughput;
    localparam int NREQ = 20;
    int n_rsp;
    n_rsp = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c <= NREQ + LAT + 1; c++) begin
      @(posedge clk); #1;
      req_valid = (c < NREQ); req_addr = 32'h400 + 32'(8 * c);
      req_id = 4'(c); req_last = ((c % 4) == 3);
      @(negedge clk);
      if (c < NREQ) begin
        checks++; if (sif_rd_en !== 1'b1) begin failures++; $display("FAIL tput_issue c=%0d got=%b exp=1", c, sif_rd_en); end
      end
      if (c >= LAT && c < NREQ) begin
        checks++;
        if (rsp_valid !== 1'b1 || occupancy !== 3'(LAT)) begin
          failures++; $display("FAIL tput_steady c=%0d got=%b/%0d exp=1/%0d", c, rsp_valid, occupancy, LAT);
        end
      end
      if (c == NREQ + LAT) begin
        checks++;
        if (rsp_valid !== 1'b0 || occupancy !== 3'd0) begin
          failures++; $display("FAIL tput_end got=%b/%0d exp=0/0", rsp_valid, occupancy);
        end
      end
      if (rsp_valid) begin
        checks++;
        if (rsp_data !== mem_data(32'h400 + 32'(8 * n_rsp)) || rsp_id !== 4'(n_rsp) ||
            rsp_last !== ((n_rsp % 4) == 3)) begin
          failures++; $display("FAIL tput_beat n=%0d got=%h/%h/%b", n_rsp, rsp_data, rsp_id, rsp_last);
        end
        n_rsp++;
      end
    end
    checks++; if (n_rsp != NREQ) begin failures++; $display("FAIL tput_count got=%0d exp=%0d", n_rsp, NREQ); end
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 32'h500 + 32'(8 * c); req_id = 4'(c); req_last = 1'b0;
      @(negedge clk);
      checks++; if (sif_rd_en !== 1'b1) begin failures++; $display("FAIL rmid_issue c=%0d got=%b exp=1", c, sif_rd_en); end
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h5F0;
    @(negedge clk);
    checks++; if (sif_rd_en !== 1'b0) begin failures++; $display("FAIL rmid_en_in_reset got=%b exp=0", sif_rd_en); end
    checks++; if (occupancy !== 3'd4 || rsp_valid !== 1'b1 || rsp_data !== mem_data(32'h500)) begin
      failures++; $display("FAIL rmid_pre got=%0d/%b/%h exp=4/1/%h", occupancy, rsp_valid, rsp_data, mem_data(32'h500));
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || occupancy !== 3'd0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_post got=%b/%0d/%b exp=0/0/1", rsp_valid, occupancy, req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_late c=%0d got=%b exp=0", c, rsp_valid); end
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h600; req_id = 4'd9; req_last = 1'b1;
    @(negedge clk);
    checks++; if (sif_rd_en !== 1'b1) begin failures++; $display("FAIL rmid_new_en got=%b exp=1", sif_rd_en); end
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      if (k == LAT) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== mem_data(32'h600) || rsp_id !== 4'd9 || rsp_last !== 1'b1) begin
          failures++; $display("FAIL rmid_new_beat got=%b/%h/%h/%b", rsp_valid, rsp_data, rsp_id, rsp_last);
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL rmid_new_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_stall;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 32'h700 + 32'(8 * i); req_id = 4'(5 + i); req_last = (i == 2);
      @(negedge clk);
      checks++; if (sif_rd_en !== 1'b1) begin failures++; $display("FAIL stall_issue i=%0d got=%b exp=1", i, sif_rd_en); end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== mem_data(32'h700) || rsp_id !== 4'd5 || rsp_last !== 1'b0) begin
        failures++; $display("FAIL stall_hold c=%0d got=%b/%h/%h/%b exp=1/%h/5/0", c, rsp_valid, rsp_data,
                             rsp_id, rsp_last, mem_data(32'h700));
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== mem_data(32'h700 + 32'(8 * i)) || rsp_id !== 4'(5 + i) ||
          rsp_last !== (i == 2)) begin
        failures++; $display("FAIL stall_drain i=%0d got=%b/%h/%h/%b", i, rsp_valid, rsp_data, rsp_id, rsp_last);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || occupancy !== 3'd0) begin
      failures++; $display("FAIL stall_end got=%b/%0d exp=0/0", rsp_valid, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit();
    test_back_to_back();
    test_throughput();
    test_reset_mid();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
